// File: rtl/pixel_arb_pkg.sv
`default_nettype none
// pixel_arb_pkg: shared types and constants for the frame BRAM write arbiter.
package pixel_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    MD1  = 2'b01,
    MD2  = 2'b10
  } owner_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  function automatic int frame_pix(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_write_arbiter_fifo.sv
`default_nettype none
// pixel_fifo: small synchronous FIFO with flush, occupancy and full/empty flags.
module pixel_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over a same-cycle push or pop; a push into a full FIFO is dropped.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// pixel_write_arbiter: grants frame BRAM port A to one pixel stream per frame,
// buffering both streams and counting every discarded pixel.
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int MAX_ROW    = 540,
  parameter int MAX_COL    = 540,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        md1_pixel_i,
  input  logic              md1_pixel_en_i,
  input  logic [7:0]        md2_pixel_i,
  input  logic              md2_pixel_en_i,
  input  logic              clear_i,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [7:0]        d2mema_o,
  output logic [1:0]        owner_o,
  output logic              frame_done_o,
  output logic [15:0]       drop_cnt_o,
  output logic              overflow_o
);

  localparam int                FRAME_PIX = frame_pix(MAX_ROW, MAX_COL);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int                INC_W     = CNT_W + 2;

  state_t            state;
  logic [ADDR_W-1:0] addr;

  logic             push1, pop1, flush1, full1, empty1;
  logic             push2, pop2, flush2, full2, empty2;
  logic [7:0]       dout1, dout2;
  logic [CNT_W-1:0] count1, count2;

  logic             go1, go2, accept1, accept2;
  logic             ovf1, ovf2, disc1, disc2;
  logic             write, last_write;
  logic [7:0]       wdata;
  logic [CNT_W-1:0] flushed;
  logic [INC_W-1:0] drop_inc;
  logic [16:0]      drop_sum;

  // In IDLE the loser of arbitration is flushed and stops accepting pixels.
  assign go1     = (state == IDLE) && !empty1;
  assign go2     = (state == IDLE) && empty1 && !empty2;
  assign accept1 = (state == GRANT1) || ((state == IDLE) && !go2);
  assign accept2 = (state == GRANT2) || ((state == IDLE) && !go1);

  assign push1 = !clear_i && md1_pixel_en_i && accept1 && !full1;
  assign push2 = !clear_i && md2_pixel_en_i && accept2 && !full2;
  assign ovf1  = !clear_i && md1_pixel_en_i && accept1 && full1;
  assign ovf2  = !clear_i && md2_pixel_en_i && accept2 && full2;
  assign disc1 = !clear_i && md1_pixel_en_i && !accept1;
  assign disc2 = !clear_i && md2_pixel_en_i && !accept2;

  assign flush1 = clear_i || go2;
  assign flush2 = clear_i || go1;
  assign pop1   = !clear_i && (state == GRANT1) && !empty1;
  assign pop2   = !clear_i && (state == GRANT2) && !empty2;

  assign write      = pop1 || pop2;
  assign wdata      = pop1 ? dout1 : dout2;
  assign last_write = write && (addr == LAST_ADDR);

  assign flushed  = go2 ? count1 : (go1 ? count2 : '0);
  assign drop_inc = INC_W'(flushed) + INC_W'(disc1) + INC_W'(disc2)
                  + INC_W'(ovf1) + INC_W'(ovf2);
  assign drop_sum = {1'b0, drop_cnt_o} + 17'(drop_inc);

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .din   (md1_pixel_i),
    .pop   (pop1),
    .flush (flush1),
    .dout  (dout1),
    .count (count1),
    .full  (full1),
    .empty (empty1)
  );

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2),
    .din   (md2_pixel_i),
    .pop   (pop2),
    .flush (flush2),
    .dout  (dout2),
    .count (count2),
    .full  (full2),
    .empty (empty2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      ena_o        <= 1'b0;
      addra_o      <= '0;
      d2mema_o     <= '0;
      owner_o      <= NONE;
      frame_done_o <= 1'b0;
      drop_cnt_o   <= '0;
      overflow_o   <= 1'b0;
    end else if (clear_i) begin
      state        <= IDLE;
      addr         <= '0;
      ena_o        <= 1'b0;
      owner_o      <= NONE;
      frame_done_o <= 1'b0;
      drop_cnt_o   <= '0;
      overflow_o   <= 1'b0;
    end else begin
      ena_o        <= write;
      frame_done_o <= last_write;
      if (write) begin
        addra_o  <= addr;
        d2mema_o <= wdata;
        addr     <= last_write ? '0 : addr + ADDR_W'(1);
      end
      if (ovf1 || ovf2) overflow_o <= 1'b1;
      drop_cnt_o <= drop_sum[16] ? DROP_MAX : drop_sum[15:0];
      case (state)
        IDLE: begin
          if (go1) begin
            state   <= GRANT1;
            owner_o <= MD1;
          end else if (go2) begin
            state   <= GRANT2;
            owner_o <= MD2;
          end
        end
        GRANT1, GRANT2: begin
          if (last_write) begin
            state   <= IDLE;
            owner_o <= NONE;
          end
        end
        default: begin
          state   <= IDLE;
          owner_o <= NONE;
        end
      endcase
    end
  end

  assign wea_o = ena_o;

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_arbiter.sv
`default_nettype none
// tb_pixel_write_arbiter: directed and random stimulus against a queue-based
// reference model of the arbiter, checked every cycle.
module tb_pixel_write_arbiter;

  localparam int MAX_ROW = 2;
  localparam int MAX_COL = 3;
  localparam int FP      = MAX_ROW * MAX_COL;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 19;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        md1_pixel_i = '0;
  logic              md1_pixel_en_i = 1'b0;
  logic [7:0]        md2_pixel_i = '0;
  logic              md2_pixel_en_i = 1'b0;
  logic              clear_i = 1'b0;
  logic              ena_o, wea_o, frame_done_o, overflow_o;
  logic [ADDR_W-1:0] addra_o;
  logic [7:0]        d2mema_o;
  logic [1:0]        owner_o;
  logic [15:0]       drop_cnt_o;

  pixel_write_arbiter #(
    .MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .md1_pixel_i   (md1_pixel_i),
    .md1_pixel_en_i(md1_pixel_en_i),
    .md2_pixel_i   (md2_pixel_i),
    .md2_pixel_en_i(md2_pixel_en_i),
    .clear_i       (clear_i),
    .ena_o         (ena_o),
    .wea_o         (wea_o),
    .addra_o       (addra_o),
    .d2mema_o      (d2mema_o),
    .owner_o       (owner_o),
    .frame_done_o  (frame_done_o),
    .drop_cnt_o    (drop_cnt_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-source queues, current owner (0 none, 1 md1, 2 md2).
  int q1[$];
  int q2[$];
  int own, m_addr, exp_drop;
  logic        exp_ena, exp_done, exp_ovf;
  logic [31:0] exp_addra, exp_data;

  int wl_addr[$];
  int wl_data[$];
  int done_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete(); q2.delete();
    own = 0; m_addr = 0; exp_drop = 0;
    exp_ena = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0;
    exp_addra = 0; exp_data = 0;
  endtask

  task automatic model_step(input bit e1, input int d1, input bit e2, input int d2, input bit clr);
    int inc, win, wd;
    bit full1, full2, acc1, acc2, wr;
    exp_ena = 1'b0; exp_done = 1'b0;
    if (clr) begin
      q1.delete(); q2.delete();
      own = 0; m_addr = 0; exp_drop = 0; exp_ovf = 1'b0;
      return;
    end
    inc = 0; win = own; wr = 0; wd = 0;
    full1 = (q1.size() >= DEPTH);
    full2 = (q2.size() >= DEPTH);
    if (own == 0) begin
      if (q1.size() > 0) begin win = 1; inc += q2.size(); q2.delete(); end
      else if (q2.size() > 0) begin win = 2; inc += q1.size(); q1.delete(); end
    end
    acc1 = (win != 2);
    acc2 = (win != 1);
    if (own == 1 && q1.size() > 0) begin wr = 1; wd = q1.pop_front(); end
    if (own == 2 && q2.size() > 0) begin wr = 1; wd = q2.pop_front(); end
    if (e1) begin
      if (!acc1) inc++;
      else if (full1) begin inc++; exp_ovf = 1'b1; end
      else q1.push_back(d1);
    end
    if (e2) begin
      if (!acc2) inc++;
      else if (full2) begin inc++; exp_ovf = 1'b1; end
      else q2.push_back(d2);
    end
    if (wr) begin
      exp_ena = 1'b1; exp_addra = m_addr; exp_data = wd;
      if (m_addr == FP - 1) begin exp_done = 1'b1; m_addr = 0; own = 0; end
      else m_addr++;
    end else if (own == 0) begin
      own = win;
    end
    exp_drop = (exp_drop + inc > 65535) ? 65535 : exp_drop + inc;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ena"},   ena_o,        exp_ena);
    chk({tag, ".wea"},   wea_o,        exp_ena);
    chk({tag, ".addr"},  addra_o,      exp_addra);
    chk({tag, ".data"},  d2mema_o,     exp_data);
    chk({tag, ".owner"}, owner_o,      own);
    chk({tag, ".done"},  frame_done_o, exp_done);
    chk({tag, ".drop"},  drop_cnt_o,   exp_drop);
    chk({tag, ".ovf"},   overflow_o,   exp_ovf);
    if (ena_o === 1'b1) begin
      wl_addr.push_back(int'(addra_o));
      wl_data.push_back(int'(d2mema_o));
    end
    if (frame_done_o === 1'b1) done_addr.push_back(int'(addra_o));
  endtask

  task automatic cyc(input bit e1, input int d1, input bit e2, input int d2, input bit clr, input string tag);
    @(negedge clk);
    md1_pixel_en_i = e1; md1_pixel_i = 8'(d1);
    md2_pixel_en_i = e2; md2_pixel_i = 8'(d2);
    clear_i = clr;
    @(posedge clk);
    model_step(e1, d1, e2, d2, clr);
    #1 check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    md1_pixel_en_i = 1'b0; md2_pixel_en_i = 1'b0; clear_i = 1'b0;
    #1 model_reset();
    check_all("reset");
    @(posedge clk);
    #1 check_all("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    wl_addr.delete(); wl_data.delete(); done_addr.delete();
  endtask

  initial begin
    model_reset();

    // Single-source frame.
    do_reset();
    for (int i = 0; i < FP; i++) cyc(1, 'h10 + i, 0, 0, 0, "s1");
    idle(4, "s1");
    chk("s1_nwrites", wl_addr.size(), FP);
    for (int i = 0; i < wl_addr.size() && i < FP; i++) begin
      chk("s1_wr_addr", wl_addr[i], i);
      chk("s1_wr_data", wl_data[i], 'h10 + i);
    end
    chk("s1_ndone", done_addr.size(), 1);
    if (done_addr.size() > 0) chk("s1_done_addr", done_addr[0], FP - 1);
    chk("s1_drop", drop_cnt_o, 0);
    chk("s1_owner_end", owner_o, 2'b00);

    // Tie in IDLE: md1 wins, md2 entry flushed and counted.
    do_reset();
    cyc(1, 'hAA, 1, 'hBB, 0, "s2");
    idle(3, "s2");
    chk("s2_nwrites", wl_addr.size(), 1);
    if (wl_addr.size() > 0) begin
      chk("s2_first_addr", wl_addr[0], 0);
      chk("s2_first_data", wl_data[0], 'hAA);
    end
    chk("s2_drop", drop_cnt_o, 1);
    chk("s2_owner", owner_o, 2'b01);

    // Contention: md1 pushes during an md2 grant.
    do_reset();
    for (int i = 0; i < FP; i++) cyc((i >= 2 && i <= 4), 'hE0 + i, 1, 'h20 + i, 0, "s3");
    idle(6, "s3");
    chk("s3_drop", drop_cnt_o, 3);
    chk("s3_nwrites", wl_addr.size(), FP);
    for (int i = 0; i < wl_addr.size() && i < FP; i++) begin
      chk("s3_wr_addr", wl_addr[i], i);
      chk("s3_wr_data", wl_data[i], 'h20 + i);
    end

    // Wrap and re-arbitration: 8 pixels from md2.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 'h30 + i, 0, "s4");
    idle(8, "s4");
    chk("s4_nwrites", wl_addr.size(), 8);
    for (int i = 0; i < wl_addr.size() && i < 8; i++) begin
      chk("s4_wr_addr", wl_addr[i], (i < FP) ? i : i - FP);
      chk("s4_wr_data", wl_data[i], 'h30 + i);
    end
    chk("s4_ndone", done_addr.size(), 1);

    // Clear mid-frame after three writes.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 'h40 + i, 0, 0, 0, "s5");
    cyc(0, 0, 1, 'hCC, 1, "s5_clear");
    cyc(1, 'h50, 0, 0, 0, "s5");
    idle(4, "s5");
    chk("s5_nwrites", wl_addr.size(), 4);
    if (wl_addr.size() == 4) begin
      chk("s5_post_addr", wl_addr[3], 0);
      chk("s5_post_data", wl_data[3], 'h50);
    end
    chk("s5_drop", drop_cnt_o, 0);
    chk("s5_ndone", done_addr.size(), 0);

    // Asynchronous reset between clock edges during a grant.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 'h60 + i, 0, 0, 0, "s6");
    chk("s6_pre_ena", ena_o, 1'b1);
    #1 rst = 1'b1;
    #1 model_reset();
    check_all("s6_async");
    @(posedge clk);
    #1 check_all("s6_async_hold");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with occasional clears.
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      int p1, p2;
      p1 = $urandom_range(10, 100);
      p2 = $urandom_range(10, 100);
      for (int i = 0; i < 500; i++) begin
        cyc($urandom_range(0, 99) < p1, $urandom_range(0, 255),
            $urandom_range(0, 99) < p2, $urandom_range(0, 255),
            $urandom_range(0, 299) == 0, "rand");
      end
    end

    // Both sources at full rate long enough to saturate the drop counter.
    do_reset();
    for (int i = 0; i < 62000; i++)
      cyc(1, $urandom_range(0, 255), 1, $urandom_range(0, 255), 0, "sat");
    chk("sat_drop", drop_cnt_o, 16'hFFFF);
    chk("sat_ovf", overflow_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
